chan_mix_sched: RTL



---
 rtl/mix_pkg.sv | 23 ++
 rtl/sample_tick_gen.sv | 42 ++++
 rtl/chan_mix_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mix_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mix_pkg
// Purpose : Shared constants and FSM state type for the four-channel mixer
//           scheduler.
// Rev     : 1.0  initial release
// ============================================================================
package mix_pkg;

   localparam int NCH   = 4;
   localparam int W     = 8;
   localparam int ACC_W = W + 2;
   localparam int ATT_W = 2;
   localparam int IDX_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : sample_tick_gen
// Purpose : Output-sample-rate divider. Counts 0..DIV-1 and raises tick for
//           one cycle on the last count of every period.
// Rev     : 1.0  initial release
// ============================================================================
module sample_tick_gen #(
   parameter int DIV = 256
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   // Reject divider values outside the supported range at elaboration time.
   generate
      if (DIV < 8 || DIV > 65536) begin : g_div_range_err
         $error("sample_tick_gen: DIV must be within 8..65536");
      end
   endgenerate

   logic [CNT_W-1:0] count;

   // Free-running period counter, wrapping after DIV-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/chan_mix_sched.sv
`default_nettype none
// ============================================================================
// Module  : chan_mix_sched
// Purpose : Frame-rate scheduler for the four-channel mixer. Snapshots the
//           channel samples once per output period, accumulates them one
//           channel per clock through a shared shift-and-add stage and
//           publishes the mixed sample with a one-cycle valid strobe.
// Config  : MIX_AVG_EN - when defined, publish the four-slot average
//           (acc/4) instead of the saturating sum; clip then stays 0.
// Rev     : 1.0  initial release
// ============================================================================
module chan_mix_sched
   import mix_pkg::*;
#(
   parameter int DIV = 256,
   parameter int W   = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] chl1,
   input  logic [W-1:0] chl2,
   input  logic [W-1:0] chl3,
   input  logic [W-1:0] chl4,
   input  logic [3:0]   ch_en,
   input  logic [7:0]   atten,
   input  logic         mute,
   output logic [W-1:0] sound_out,
   output logic         sample_valid,
   output logic         clip,
   output logic         busy
);

   // Sum of four W-bit samples fits in W+2 bits, so the accumulator never wraps.
   localparam int SUM_W = W + 2;
   localparam logic [SUM_W-1:0] SAT_LIMIT = {2'b00, {W{1'b1}}};

   state_t               state;
   logic [W-1:0]         snap_ch [NCH];
   logic [NCH-1:0]       snap_en;
   logic [NCH*ATT_W-1:0] snap_att;
   logic                 snap_mute;
   logic [SUM_W-1:0]     acc;
   logic [IDX_W-1:0]     idx;
   logic                 tick;
   logic [ATT_W-1:0]     cur_att;
   logic [SUM_W-1:0]     addend;

   sample_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Shared shift stage: attenuated sample of the channel selected by idx.
   always_comb begin
      cur_att = snap_att[ATT_W*int'(idx) +: ATT_W];
      addend  = SUM_W'(snap_ch[idx]) >> cur_att;
   end

   // Frame sequencer: snapshot on tick, accumulate one slot per cycle, publish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         acc          <= '0;
         idx          <= '0;
         snap_en      <= '0;
         snap_att     <= '0;
         snap_mute    <= 1'b0;
         sound_out    <= '0;
         sample_valid <= 1'b0;
         clip         <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            snap_ch[i] <= '0;
         end
      end else begin
         sample_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (tick) begin
                  snap_ch[0] <= chl1;
                  snap_ch[1] <= chl2;
                  snap_ch[2] <= chl3;
                  snap_ch[3] <= chl4;
                  snap_en    <= ch_en;
                  snap_att   <= atten;
                  snap_mute  <= mute;
                  acc        <= '0;
                  idx        <= '0;
                  state      <= ACC;
               end
            end
            ACC: begin
               if (snap_en[idx]) begin
                  acc <= acc + addend;
               end
               idx <= idx + 1'b1;
               if (idx == IDX_W'(NCH - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
`ifdef MIX_AVG_EN
               sound_out <= snap_mute ? '0 : acc[SUM_W-1:2];
               clip      <= 1'b0;
`else
               if (snap_mute) begin
                  sound_out <= '0;
                  clip      <= 1'b0;
               end else if (acc > SAT_LIMIT) begin
                  sound_out <= {W{1'b1}};
                  clip      <= 1'b1;
               end else begin
                  sound_out <= acc[W-1:0];
                  clip      <= 1'b0;
               end
`endif
               sample_valid <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
`default_nettype wire
